// File: rtl/liteic_slave_node_read_arb_if.sv
// Bus bundle for the liteic read-path slave node: per-master AR/R handshakes plus the slave AXI-Lite AR/R channels.
// The slave modport is the arbiter's view; the master modport is the crossbar/slave-side environment.
interface liteic_slave_node_read_arb_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int RDATA_WIDTH = 34
);
    logic [NUM_MASTERS-1:0] mst_reqst_val_i;
    logic [NUM_MASTERS-1:0] mst_reqst_rdy_o;
    logic [ADDR_WIDTH-1:0]  mst_reqst_data_i [NUM_MASTERS];
    logic [3:0]             mst_reqst_arqos_i [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] mst_resp_val_o;
    logic [NUM_MASTERS-1:0] mst_resp_rdy_i;
    logic [RDATA_WIDTH-1:0] mst_resp_data_o;
    logic                   slv_ar_valid_o;
    logic                   slv_ar_ready_i;
    logic [ADDR_WIDTH-1:0]  slv_ar_addr_o;
    logic [3:0]             slv_ar_qos_o;
    logic                   slv_r_valid_i;
    logic                   slv_r_ready_o;
    logic [RDATA_WIDTH-1:0] slv_r_data_i;

    modport slave (
        input  mst_reqst_val_i, mst_reqst_data_i, mst_reqst_arqos_i, mst_resp_rdy_i,
        input  slv_ar_ready_i, slv_r_valid_i, slv_r_data_i,
        output mst_reqst_rdy_o, mst_resp_val_o, mst_resp_data_o,
        output slv_ar_valid_o, slv_ar_addr_o, slv_ar_qos_o, slv_r_ready_o
    );

    modport master (
        output mst_reqst_val_i, mst_reqst_data_i, mst_reqst_arqos_i, mst_resp_rdy_i,
        output slv_ar_ready_i, slv_r_valid_i, slv_r_data_i,
        input  mst_reqst_rdy_o, mst_resp_val_o, mst_resp_data_o,
        input  slv_ar_valid_o, slv_ar_addr_o, slv_ar_qos_o, slv_r_ready_o
    );
endinterface

// File: rtl/liteic_slave_node_read_arb.sv
// Read-path slave node: arbitrates master AR requests onto one AXI-Lite slave, one read outstanding.
// Define LITEIC_RD_ARB_QOS_EN to arbitrate by highest QoS (round-robin tie break); default is pure round-robin.
module liteic_slave_node_read_arb #(
    parameter int NUM_MASTERS  = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int RDATA_WIDTH  = 34,
    parameter int MST_ID_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    liteic_slave_node_read_arb_if.slave bus,
    output logic                        busy_o,
    output logic [MST_ID_WIDTH-1:0]     grant_id_o
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [MST_ID_WIDTH-1:0] r_rr_ptr;
    logic [MST_ID_WIDTH-1:0] r_grant_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [3:0]              r_qos;

    logic                    w_any_req;
    logic                    w_found;
    logic [MST_ID_WIDTH-1:0] w_idx;
    logic [MST_ID_WIDTH-1:0] w_winner;
    logic [MST_ID_WIDTH-1:0] w_rr_next;
    logic                    w_r_hs;
    logic                    w_ar_valid;
    logic                    w_r_ready;
    logic [NUM_MASTERS-1:0]  w_reqst_rdy;
    logic [NUM_MASTERS-1:0]  w_resp_val;
    logic [RDATA_WIDTH-1:0]  w_r_data;
`ifdef LITEIC_RD_ARB_QOS_EN
    logic [3:0]              w_best_qos;
`endif

    function automatic logic [MST_ID_WIDTH-1:0] rr_idx(input logic [MST_ID_WIDTH-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return MST_ID_WIDTH'(s);
    endfunction

    // Scan in round-robin order from rr_ptr; the first hit wins (or the first hit of the highest QoS).
    always_comb begin
        w_any_req = |bus.mst_reqst_val_i;
        w_found   = 1'b0;
        w_idx     = '0;
        w_winner  = '0;
`ifdef LITEIC_RD_ARB_QOS_EN
        w_best_qos = '0;
`endif
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = rr_idx(r_rr_ptr, k);
`ifdef LITEIC_RD_ARB_QOS_EN
            if (bus.mst_reqst_val_i[w_idx] && (!w_found || (bus.mst_reqst_arqos_i[w_idx] > w_best_qos))) begin
                w_found    = 1'b1;
                w_winner   = w_idx;
                w_best_qos = bus.mst_reqst_arqos_i[w_idx];
            end
`else
            if (bus.mst_reqst_val_i[w_idx] && !w_found) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
`endif
        end
    end

    assign w_rr_next = (r_grant_id == MST_ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : r_grant_id + MST_ID_WIDTH'(1);
    assign w_r_hs    = (r_state == S_RESP) && bus.slv_r_valid_i && bus.mst_resp_rdy_i[r_grant_id];

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ar_valid   = 1'b0;
        w_r_ready    = 1'b0;
        case (r_state)
            S_IDLE: if (w_any_req) w_state_next = S_ADDR;
            S_ADDR: begin
                w_ar_valid = 1'b1;
                if (bus.slv_ar_ready_i) w_state_next = S_RESP;
            end
            S_RESP: begin
                w_r_ready = bus.mst_resp_rdy_i[r_grant_id];
                if (w_r_hs) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address and QoS are captured once at grant time so they stay stable under AR backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_addr     <= '0;
            r_qos      <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_grant_id <= w_winner;
                r_addr     <= bus.mst_reqst_data_i[w_winner];
                r_qos      <= bus.mst_reqst_arqos_i[w_winner];
            end
            if (w_r_hs) r_rr_ptr <= w_rr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_mst
            assign w_reqst_rdy[gi] = (r_state == S_ADDR) && (r_grant_id == MST_ID_WIDTH'(gi)) && bus.slv_ar_ready_i;
            assign w_resp_val[gi]  = (r_state == S_RESP) && (r_grant_id == MST_ID_WIDTH'(gi)) && bus.slv_r_valid_i;
        end
    endgenerate

    assign w_r_data            = bus.slv_r_data_i;
    assign bus.mst_resp_data_o = w_r_data;
    assign bus.mst_reqst_rdy_o = w_reqst_rdy;
    assign bus.mst_resp_val_o  = w_resp_val;
    assign bus.slv_ar_valid_o  = w_ar_valid;
    assign bus.slv_ar_addr_o   = r_addr;
    assign bus.slv_ar_qos_o    = r_qos;
    assign bus.slv_r_ready_o   = w_r_ready;
    assign busy_o              = (r_state != S_IDLE);
    assign grant_id_o          = r_grant_id;
endmodule

// File: tb/tb_liteic_slave_node_read_arb.sv
// Directed bench for liteic_slave_node_read_arb: expected AR/R beats are queued as stimulus is driven
// and popped when the matching handshake is seen; the QoS section runs only with LITEIC_RD_ARB_QOS_EN.
module tb_liteic_slave_node_read_arb;
    typedef struct packed {
        logic [1:0]  mst;
        logic [31:0] addr;
        logic [3:0]  qos;
    } ar_t;

    typedef struct packed {
        logic [1:0]  mst;
        logic [33:0] data;
    } r_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [1:0] grant_id;

    ar_t ar_q[$];
    r_t  r_q[$];
    int  checks = 0;
    int  errors = 0;
    int  ar_hs  = 0;
    int  r_hs   = 0;
    int  ar_hs0;
    int  r_hs0;

    liteic_slave_node_read_arb_if #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .RDATA_WIDTH(34)) bus ();

    liteic_slave_node_read_arb #(
        .NUM_MASTERS(4),
        .ADDR_WIDTH (32),
        .RDATA_WIDTH(34)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .busy_o    (busy),
        .grant_id_o(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ar_t mk_ar(input int m, input logic [31:0] a, input logic [3:0] q);
        ar_t t;
        t.mst  = 2'(m);
        t.addr = a;
        t.qos  = q;
        return t;
    endfunction

    function automatic r_t mk_r(input int m, input logic [33:0] d);
        r_t t;
        t.mst  = 2'(m);
        t.data = d;
        return t;
    endfunction

    // Sample handshakes that the next rising edge will commit, then move to the following falling edge.
    task automatic cyc();
        ar_t ea;
        r_t  er;
        #1;
        if (!rst) begin
            if (bus.slv_ar_valid_o && bus.slv_ar_ready_i) begin
                ar_hs++;
                check("ar_expected", 64'(ar_q.size() != 0), 64'(1));
                if (ar_q.size() != 0) begin
                    ea = ar_q.pop_front();
                    check("ar_rdy", 64'(bus.mst_reqst_rdy_o), 64'(4'b0001 << ea.mst));
                    check("ar_grant", 64'(grant_id), 64'(ea.mst));
                    check("ar_addr", 64'(bus.slv_ar_addr_o), 64'(ea.addr));
                    check("ar_qos", 64'(bus.slv_ar_qos_o), 64'(ea.qos));
                end
            end
            if (bus.slv_r_valid_i && bus.slv_r_ready_o) r_hs++;
            for (int m = 0; m < 4; m++) begin
                if (bus.mst_resp_val_o[m] && bus.mst_resp_rdy_i[m]) begin
                    check("r_expected", 64'(r_q.size() != 0), 64'(1));
                    if (r_q.size() != 0) begin
                        er = r_q.pop_front();
                        check("r_mst", 64'(m), 64'(er.mst));
                        check("r_data", 64'(bus.mst_resp_data_o), 64'(er.data));
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_drained(input string tag);
        for (int c = 0; c < 60 && r_q.size() != 0; c++) cyc();
        check({tag, "_r_drained"}, 64'(r_q.size()), 64'(0));
        check({tag, "_ar_drained"}, 64'(ar_q.size()), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus.mst_reqst_val_i = '0;
        bus.mst_resp_rdy_i  = '0;
        bus.slv_ar_ready_i  = 1'b0;
        bus.slv_r_valid_i   = 1'b0;
        bus.slv_r_data_i    = 34'h2_AAAA_5555;
        for (int m = 0; m < 4; m++) begin
            bus.mst_reqst_data_i[m]  = '0;
            bus.mst_reqst_arqos_i[m] = '0;
        end
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant", 64'(grant_id), 64'(0));
        check("rst_arvalid", 64'(bus.slv_ar_valid_o), 64'(0));
        check("rst_rready", 64'(bus.slv_r_ready_o), 64'(0));
        check("rst_reqrdy", 64'(bus.mst_reqst_rdy_o), 64'(0));
        check("rst_respval", 64'(bus.mst_resp_val_o), 64'(0));
        check("rst_data_pass", 64'(bus.mst_resp_data_o), 64'(34'h2_AAAA_5555));
        rst = 1'b0;

        // Single read from master 2
        bus.mst_reqst_data_i[2]  = 32'h0000_1040;
        bus.mst_reqst_arqos_i[2] = 4'h0;
        bus.mst_reqst_val_i      = 4'b0100;
        bus.slv_ar_ready_i       = 1'b1;
        bus.mst_resp_rdy_i       = 4'b1111;
        ar_q.push_back(mk_ar(2, 32'h0000_1040, 4'h0));
        r_q.push_back(mk_r(2, {32'h1234_5678, 2'b00}));
        #1 check("t1_no_arvalid_in_idle", 64'(bus.slv_ar_valid_o), 64'(0));
        cyc();
        check("t1_arvalid_next_cycle", 64'(bus.slv_ar_valid_o), 64'(1));
        check("t1_reqrdy", 64'(bus.mst_reqst_rdy_o), 64'(4'b0100));
        check("t1_busy", 64'(busy), 64'(1));
        cyc();
        bus.mst_reqst_val_i = '0;
        bus.slv_ar_ready_i  = 1'b0;
        bus.slv_r_valid_i   = 1'b1;
        bus.slv_r_data_i    = {32'h1234_5678, 2'b00};
        #1 check("t1_reqrdy_dropped", 64'(bus.mst_reqst_rdy_o), 64'(0));
        check("t1_respval", 64'(bus.mst_resp_val_o), 64'(4'b0100));
        cyc();
        bus.slv_r_valid_i = 1'b0;
        #1 check("t1_busy_done", 64'(busy), 64'(0));
        check("t1_respval_done", 64'(bus.mst_resp_val_o), 64'(0));
        check("t1_ar_hs", 64'(ar_hs), 64'(1));
        check("t1_r_hs", 64'(r_hs), 64'(1));

        rst = 1'b1;
        cyc();
        rst = 1'b0;

`ifndef LITEIC_RD_ARB_QOS_EN
        // Round-robin among masters 0, 1, 3; QoS differs but must not affect the order
        bus.mst_reqst_data_i[0]  = 32'h0000_2000;
        bus.mst_reqst_data_i[1]  = 32'h0000_2010;
        bus.mst_reqst_data_i[3]  = 32'h0000_2030;
        bus.mst_reqst_arqos_i[0] = 4'h1;
        bus.mst_reqst_arqos_i[1] = 4'h4;
        bus.mst_reqst_arqos_i[3] = 4'hF;
        for (int rep = 0; rep < 2; rep++) begin
            ar_q.push_back(mk_ar(0, 32'h0000_2000, 4'h1));
            ar_q.push_back(mk_ar(1, 32'h0000_2010, 4'h4));
            ar_q.push_back(mk_ar(3, 32'h0000_2030, 4'hF));
            r_q.push_back(mk_r(0, 34'h0_BEEF_0001));
            r_q.push_back(mk_r(1, 34'h0_BEEF_0001));
            r_q.push_back(mk_r(3, 34'h0_BEEF_0001));
        end
        bus.slv_r_data_i    = 34'h0_BEEF_0001;
        bus.mst_reqst_val_i = 4'b1011;
        bus.slv_ar_ready_i  = 1'b1;
        bus.slv_r_valid_i   = 1'b1;
        bus.mst_resp_rdy_i  = 4'b1111;
        run_until_drained("rr");
`else
        // QoS: 1 and 3 tie at the top, 0 waits until they withdraw
        bus.mst_reqst_data_i[0]  = 32'h0000_2000;
        bus.mst_reqst_data_i[1]  = 32'h0000_2010;
        bus.mst_reqst_data_i[3]  = 32'h0000_2030;
        bus.mst_reqst_arqos_i[0] = 4'h2;
        bus.mst_reqst_arqos_i[1] = 4'h9;
        bus.mst_reqst_arqos_i[3] = 4'h9;
        ar_q.push_back(mk_ar(1, 32'h0000_2010, 4'h9));
        ar_q.push_back(mk_ar(3, 32'h0000_2030, 4'h9));
        r_q.push_back(mk_r(1, 34'h0_BEEF_0002));
        r_q.push_back(mk_r(3, 34'h0_BEEF_0002));
        bus.slv_r_data_i    = 34'h0_BEEF_0002;
        bus.mst_reqst_val_i = 4'b1011;
        bus.slv_ar_ready_i  = 1'b1;
        bus.slv_r_valid_i   = 1'b1;
        bus.mst_resp_rdy_i  = 4'b1111;
        run_until_drained("qos_hi");
        ar_q.push_back(mk_ar(0, 32'h0000_2000, 4'h2));
        r_q.push_back(mk_r(0, 34'h0_BEEF_0002));
        bus.mst_reqst_val_i = 4'b0001;
        run_until_drained("qos_lo");
`endif
        bus.mst_reqst_val_i = '0;
        bus.slv_r_valid_i   = 1'b0;
        bus.slv_ar_ready_i  = 1'b0;

        // Backpressure on both channels, with a stray R beat before RESP
        bus.mst_reqst_data_i[1]  = 32'hDEAD_BEE0;
        bus.mst_reqst_arqos_i[1] = 4'h5;
        bus.mst_reqst_val_i      = 4'b0010;
        bus.slv_r_valid_i        = 1'b1;
        bus.slv_r_data_i         = 34'h1_5A5A_A5A5;
        bus.mst_resp_rdy_i       = 4'b1111;
        ar_hs0 = ar_hs;
        r_hs0  = r_hs;
        ar_q.push_back(mk_ar(1, 32'hDEAD_BEE0, 4'h5));
        r_q.push_back(mk_r(1, 34'h1_5A5A_A5A5));
        #1 check("stray_idle_rready", 64'(bus.slv_r_ready_o), 64'(0));
        check("stray_idle_respval", 64'(bus.mst_resp_val_o), 64'(0));
        cyc();
        bus.mst_reqst_val_i = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            #1 check("bp_arvalid", 64'(bus.slv_ar_valid_o), 64'(1));
            check("bp_addr", 64'(bus.slv_ar_addr_o), 64'(32'hDEAD_BEE0));
            check("bp_qos", 64'(bus.slv_ar_qos_o), 64'(4'h5));
            check("bp_reqrdy", 64'(bus.mst_reqst_rdy_o), 64'(0));
            check("stray_addr_rready", 64'(bus.slv_r_ready_o), 64'(0));
            check("stray_addr_respval", 64'(bus.mst_resp_val_o), 64'(0));
            cyc();
        end
        bus.slv_ar_ready_i = 1'b1;
        #1 check("bp_reqrdy_release", 64'(bus.mst_reqst_rdy_o), 64'(4'b0010));
        cyc();
        bus.mst_reqst_val_i = '0;
        bus.slv_ar_ready_i  = 1'b0;
        bus.mst_resp_rdy_i  = '0;
        for (int c = 0; c < 3; c++) begin
            #1 check("bp_rready_low", 64'(bus.slv_r_ready_o), 64'(0));
            check("bp_respval", 64'(bus.mst_resp_val_o), 64'(4'b0010));
            check("bp_data_pass", 64'(bus.mst_resp_data_o), 64'(34'h1_5A5A_A5A5));
            cyc();
        end
        bus.mst_resp_rdy_i = 4'b0010;
        #1 check("bp_rready_high", 64'(bus.slv_r_ready_o), 64'(1));
        cyc();
        bus.slv_r_valid_i = 1'b0;
        check("bp_one_ar_hs", 64'(ar_hs - ar_hs0), 64'(1));
        check("bp_one_r_hs", 64'(r_hs - r_hs0), 64'(1));
        check("bp_busy_done", 64'(busy), 64'(0));
        check("bp_r_drained", 64'(r_q.size()), 64'(0));

        // Reset while in RESP with an R beat pending
        bus.mst_reqst_data_i[0]  = 32'h0000_3000;
        bus.mst_reqst_arqos_i[0] = 4'h3;
        bus.mst_reqst_val_i      = 4'b0001;
        bus.slv_ar_ready_i       = 1'b1;
        bus.slv_r_valid_i        = 1'b1;
        bus.slv_r_data_i         = 34'h0_0BAD_0BAD;
        bus.mst_resp_rdy_i       = '0;
        ar_q.push_back(mk_ar(0, 32'h0000_3000, 4'h3));
        cyc();
        cyc();
        bus.mst_reqst_val_i = '0;
        bus.slv_ar_ready_i  = 1'b0;
        #1 check("rst_pre_in_resp", 64'(bus.mst_resp_val_o), 64'(4'b0001));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1 check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_grant", 64'(grant_id), 64'(0));
        check("mrst_arvalid", 64'(bus.slv_ar_valid_o), 64'(0));
        check("mrst_rready", 64'(bus.slv_r_ready_o), 64'(0));
        check("mrst_respval", 64'(bus.mst_resp_val_o), 64'(0));
        check("mrst_reqrdy", 64'(bus.mst_reqst_rdy_o), 64'(0));
        check("mrst_addr", 64'(bus.slv_ar_addr_o), 64'(0));
        check("mrst_qos", 64'(bus.slv_ar_qos_o), 64'(0));

        // rr_ptr must be back at 0: master 0 beats master 3
        bus.mst_reqst_data_i[3]  = 32'h0000_3030;
        bus.mst_reqst_arqos_i[3] = 4'h3;
        ar_q.push_back(mk_ar(0, 32'h0000_3000, 4'h3));
        ar_q.push_back(mk_ar(3, 32'h0000_3030, 4'h3));
        r_q.push_back(mk_r(0, 34'h0_0BAD_0BAD));
        r_q.push_back(mk_r(3, 34'h0_0BAD_0BAD));
        bus.mst_reqst_val_i = 4'b1001;
        bus.slv_ar_ready_i  = 1'b1;
        bus.mst_resp_rdy_i  = 4'b1111;
        run_until_drained("post_rst");
        bus.mst_reqst_val_i = '0;
        bus.slv_r_valid_i   = 1'b0;
        bus.slv_ar_ready_i  = 1'b0;
        cyc();
        check("final_busy", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/liteic_slave_node_read_arb.md
Name: liteic_slave_node_read_arb

Overview:
Read-path slave node for the liteic crossbar.
- Arbitrates AR requests from all master nodes that target one slave slot.
- Forwards the winner's address and QoS to the slave's AXI-Lite AR channel.
- Holds the grant until the matching R beat completes, then routes that beat back to the granted master only.
- One outstanding read per slave slot.

Parameters:
- NUM_MASTERS, 4, number of master nodes connected to this slave slot (>=1).
- ADDR_WIDTH, 32, AR address width.
- RDATA_WIDTH, 34, R payload width ({r_data, r_resp}).
- MST_ID_WIDTH, (NUM_MASTERS>1 ? $clog2(NUM_MASTERS) : 1), width of the grant index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- mst_reqst_val_i  in  NUM_MASTERS  per-master AR valid from the crossbar
- mst_reqst_rdy_o  out  NUM_MASTERS  per-master AR ready
- mst_reqst_data_i  in  ADDR_WIDTH x NUM_MASTERS (unpacked array)  per-master address
- mst_reqst_arqos_i  in  4 x NUM_MASTERS (unpacked array)  per-master QoS
- mst_resp_val_o  out  NUM_MASTERS  per-master R valid
- mst_resp_rdy_i  in  NUM_MASTERS  per-master R ready
- mst_resp_data_o  out  RDATA_WIDTH  R payload, broadcast to all masters
- slv_ar_valid_o  out  1  slave AR valid
- slv_ar_ready_i  in  1  slave AR ready
- slv_ar_addr_o  out  ADDR_WIDTH  slave AR address
- slv_ar_qos_o  out  4  slave AR QoS
- slv_r_valid_i  in  1  slave R valid
- slv_r_ready_o  out  1  slave R ready
- slv_r_data_i  in  RDATA_WIDTH  slave R payload
- busy_o  out  1  high when not IDLE
- grant_id_o  out  MST_ID_WIDTH  index of the current or last granted master

Behaviour:
- FSM has three states: IDLE, ADDR, RESP.
- IDLE:
  - If any mst_reqst_val_i bit is set, pick a winner, register grant_id, address and qos, then go to ADDR.
  - No outputs are asserted in IDLE.
- Arbitration (base):
  - Round-robin: scan from rr_ptr upward, wrapping at NUM_MASTERS-1 -> 0; the first set valid bit wins.
  - rr_ptr resets to 0.
  - On R handshake completion, rr_ptr <= grant_id+1, wrapping to 0.
- ADDR:
  - slv_ar_valid_o=1; slv_ar_addr_o and slv_ar_qos_o come from registers and stay stable.
  - mst_reqst_rdy_o[grant_id] = slv_ar_ready_i; all other rdy bits are 0.
  - On slv_ar_ready_i=1, go to RESP.
  - If the granted master drops valid (protocol violation), the block stays in ADDR and keeps slv_ar_valid_o asserted; no withdrawal.
- RESP:
  - mst_resp_val_o[grant_id] = slv_r_valid_i; all other val bits are 0.
  - mst_resp_data_o = slv_r_data_i (combinational pass-through).
  - slv_r_ready_o = mst_resp_rdy_i[grant_id].
  - On slv_r_valid_i & slv_r_ready_o, update rr_ptr and go to IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle N -> slv_ar_valid_o at N+1.
  - AR accepted at the earliest in the same cycle N+1.
  - IDLE spends exactly one cycle between back-to-back transactions, so peak throughput is 1 read per 3 cycles.
- R beats arriving in IDLE or ADDR are not accepted: slv_r_ready_o=0 outside RESP.
- Reset:
  - On rst_i=1 at a clock edge, regardless of state: state=IDLE, rr_ptr=0, grant_id=0, addr/qos regs=0.
  - All valid/ready outputs = 0, busy_o=0, mst_resp_data_o follows slv_r_data_i.
  - Reset mid-transaction drops the in-flight read.
- Simultaneous events: new requests in any cycle except IDLE are ignored until the FSM returns to IDLE; requests are never queued.
- NUM_MASTERS=1: grant_id is always 0 and round-robin degenerates to that single master.

Optional Feature:
- Macro: LITEIC_RD_ARB_QOS_EN.
- Defined: the winner is the requesting master with the highest mst_reqst_arqos_i. Ties are broken round-robin from rr_ptr. rr_ptr is updated identically to the base case.
- Undefined: pure round-robin; QoS is ignored for arbitration but still registered and forwarded on slv_ar_qos_o.

Test Plan:
- Single read: master 2 requests addr 0x0000_1040, qos 0; slave ready immediately, R data 0x1234_5678 / OKAY 1 cycle later.
  -> slv_ar_valid_o 1 cycle after the request.
  -> mst_reqst_rdy_o=4'b0100 for 1 cycle.
  -> mst_resp_val_o=4'b0100 carrying 0x1234_5678/OKAY.
  -> busy_o returns to 0.
- Round-robin: masters 0, 1 and 3 hold valid continuously (macro off). -> Grant order 0,1,3,0,1,3; rr_ptr wraps from 3 to 0.
- QoS (macro on): master 0 qos=2, master 1 qos=9, master 3 qos=9, rr_ptr=0. -> Grant order 1, 3 (QoS tie resolved by RR), then master 0 only after masters 1 and 3 drop valid.
- Backpressure: slv_ar_ready_i low for 5 cycles, then mst_resp_rdy_i low for 3 cycles with slv_r_valid_i high.
  -> Address/qos stable throughout.
  -> slv_r_ready_o stays low until mst_resp_rdy_i rises.
  -> Exactly one handshake on each channel.
- Reset mid-operation: assert rst_i for 1 cycle while in RESP with slv_r_valid_i=1.
  -> Next cycle: state IDLE, all valid/ready outputs 0, rr_ptr=0, no mst_resp_val_o pulse.
- Stray R beat: slv_r_valid_i=1 while in IDLE or ADDR. -> slv_r_ready_o=0 and mst_resp_val_o=0 until the FSM reaches RESP.
